// File: rtl/econet_pkg.sv
// rtl/econet_pkg.sv - shared state encoding, FCS constants and byte-wise CRC-16/CCITT step
package econet_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    SYNC  = 2'd1,
    FRAME = 2'd2
  } rx_state_e;

  localparam logic [15:0] FCS_INIT = 16'hFFFF;
  localparam logic [15:0] FCS_POLY = 16'h8408;
  localparam logic [15:0] FCS_GOOD = 16'hF0B8;

  // Reflected CRC: data enters LSB first, matching the order bits arrive on the line.
  function automatic logic [15:0] fcs16_byte(input logic [15:0] crc,
                                             input logic [7:0]  data,
                                             input logic [15:0] poly);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ poly;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/econet_fcs16.sv
// rtl/econet_fcs16.sv - combinational one-byte CRC-16/CCITT step, shared with the transmit path
module econet_fcs16
  import econet_pkg::*;
#(
  parameter logic [15:0] POLY = econet_pkg::FCS_POLY
) (
  input  logic [15:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc_out
);

  assign crc_out = fcs16_byte(crc_in, byte_in, POLY);

endmodule

// File: rtl/econet_hdlc_rx.sv
// rtl/econet_hdlc_rx.sv - Econet HDLC receive front end: flags, abort, destuffing, bytes, FCS
// Optional ECONET_RX_SYNC_EN adds a 2-flop input synchroniser (strobes 2 cycles later).
module econet_hdlc_rx #(
  parameter logic [15:0] FCS_INIT = econet_pkg::FCS_INIT,
  parameter logic [15:0] FCS_POLY = econet_pkg::FCS_POLY
) (
  input  logic        econet_clk,
  input  logic        reset_n,
  input  logic        rx,
  output logic [7:0]  rx_byte,
  output logic [15:0] rx_fcs,
  output logic        rx_byte_ready,
  output logic        rx_frame_start,
  output logic        rx_frame_end,
  output logic        rx_abort
);
  import econet_pkg::*;

  logic rx_s;

`ifdef ECONET_RX_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge econet_clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];
`else
  assign rx_s = rx;
`endif

  rx_state_e   state_q;
  logic [2:0]  ones_q;
  logic [2:0]  cnt_q;
  logic [7:0]  shreg_q;
  logic [15:0] fcs_q;
  logic [7:0]  byte_q;
  logic        ready_q, start_q, end_q, abort_q;

  logic [2:0]  ones_d;
  logic [7:0]  shift_d;
  logic [15:0] fcs_base, fcs_d;
  logic        is_stuff, is_six, is_flag, is_abort, commit;

  assign ones_d   = !rx_s ? 3'd0 : (ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1;
  assign shift_d  = {rx_s, shreg_q[7:1]};
  assign is_stuff = !rx_s && (ones_q == 3'd5);
  assign is_six   =  rx_s && (ones_q == 3'd5);
  assign is_flag  = !rx_s && (ones_q == 3'd6);
  assign is_abort =  rx_s && (ones_q >= 3'd6);
  assign commit   = !(is_stuff || is_six || is_flag || is_abort);

  // The first byte after an opening flag restarts the CRC, so flag bits never enter it.
  assign fcs_base = (state_q == SYNC) ? FCS_INIT : fcs_q;

  econet_fcs16 #(.POLY(FCS_POLY)) u_fcs (
    .crc_in  (fcs_base),
    .byte_in (shift_d),
    .crc_out (fcs_d)
  );

  always_ff @(posedge econet_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HUNT;
      ones_q  <= 3'd0;
      cnt_q   <= 3'd0;
      shreg_q <= 8'h00;
      fcs_q   <= FCS_INIT;
      byte_q  <= 8'h00;
      ready_q <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      ones_q  <= ones_d;
      ready_q <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        HUNT: begin
          if (is_flag) begin
            state_q <= SYNC;
            cnt_q   <= 3'd0;
          end
        end
        SYNC, FRAME: begin
          if (is_flag) begin
            end_q   <= (state_q == FRAME) && (cnt_q == 3'd6);
            state_q <= SYNC;
            cnt_q   <= 3'd0;
          end else if (is_abort) begin
            // Seven ones while still between flags is just the line going idle.
            abort_q <= (state_q == FRAME);
            state_q <= HUNT;
          end else if (commit) begin
            shreg_q <= shift_d;
            cnt_q   <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              byte_q  <= shift_d;
              ready_q <= 1'b1;
              start_q <= (state_q == SYNC);
              fcs_q   <= fcs_d;
              state_q <= FRAME;
            end
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

  assign rx_byte        = byte_q;
  assign rx_fcs         = fcs_q;
  assign rx_byte_ready  = ready_q;
  assign rx_frame_start = start_q;
  assign rx_frame_end   = end_q;
  assign rx_abort       = abort_q;

endmodule

// File: tb/tb_econet_hdlc_rx.sv
// tb/tb_econet_hdlc_rx.sv - self-checking bench for econet_hdlc_rx (with or without ECONET_RX_SYNC_EN)
module tb_econet_hdlc_rx;
  import econet_pkg::*;

`ifdef ECONET_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam logic [15:0] RESIDUE = 16'hF0B8;

  logic        econet_clk = 1'b0;
  logic        reset_n    = 1'b0;
  logic        rx         = 1'b1;
  logic [7:0]  rx_byte;
  logic [15:0] rx_fcs;
  logic        rx_byte_ready, rx_frame_start, rx_frame_end, rx_abort;

  econet_hdlc_rx dut (
    .econet_clk     (econet_clk),
    .reset_n        (reset_n),
    .rx             (rx),
    .rx_byte        (rx_byte),
    .rx_fcs         (rx_fcs),
    .rx_byte_ready  (rx_byte_ready),
    .rx_frame_start (rx_frame_start),
    .rx_frame_end   (rx_frame_end),
    .rx_abort       (rx_abort)
  );

  always #5 econet_clk = ~econet_clk;

  int pcnt = 0;
  always @(posedge econet_clk) pcnt <= pcnt + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { int at; logic start; logic [7:0] data; } byte_exp_t;
  typedef struct { int at; logic [15:0] fcs; } end_exp_t;
  typedef struct { int n; logic [3:0][7:0] d; logic [15:0] residue; } vec_t;

  byte_exp_t byte_sb[$];
  end_exp_t  end_sb[$];
  int        abort_sb[$];
  byte_exp_t be;
  end_exp_t  ee;
  int        ab;
  int        tx_ones = 0;
  vec_t      vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, pcnt);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: strobe seen at cycle %0d, none expected", name, pcnt);
  endtask

  always @(negedge econet_clk) begin
    if (rx_byte_ready) begin
      if (byte_sb.size() == 0) unexpected("byte_ready");
      else begin
        be = byte_sb.pop_front();
        chk("byte_data", {24'h0, rx_byte}, {24'h0, be.data});
        chk("byte_time", pcnt, be.at);
        chk("frame_start", {31'h0, rx_frame_start}, {31'h0, be.start});
      end
    end else if (rx_frame_start) unexpected("frame_start_alone");
    if (rx_frame_end) begin
      if (end_sb.size() == 0) unexpected("frame_end");
      else begin
        ee = end_sb.pop_front();
        chk("end_time", pcnt, ee.at);
        chk("end_fcs", {16'h0, rx_fcs}, {16'h0, ee.fcs});
      end
      if (rx_byte_ready) unexpected("end_with_byte");
    end
    if (rx_abort) begin
      if (abort_sb.size() == 0) unexpected("abort");
      else begin
        ab = abort_sb.pop_front();
        chk("abort_time", pcnt, ab);
      end
      if (rx_byte_ready) unexpected("abort_with_byte");
    end
  end

  function automatic logic [15:0] ref_crc(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    logic fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ d[i];
      c  = {1'b0, c[15:1]};
      if (fb) c = c ^ 16'h8408;
    end
    return c;
  endfunction

  task automatic send_raw(input logic b, output int p);
    @(negedge econet_clk);
    rx = b;
    p  = pcnt;
  endtask

  task automatic send_ones(input int n);
    int p;
    for (int i = 0; i < n; i++) send_raw(1'b1, p);
    tx_ones = 0;
  endtask

  task automatic send_flag(output int p);
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) send_raw(f[i], p);
    tx_ones = 0;
  endtask

  task automatic send_bits(input logic [7:0] v, input int nb, input logic push, input logic start);
    int p, q;
    for (int i = 0; i < nb; i++) begin
      send_raw(v[i], p);
      if (push && i == 7) byte_sb.push_back('{at: p + 1 + LAT, start: start, data: v});
      if (v[i]) begin
        tx_ones++;
        if (tx_ones == 5) begin
          send_raw(1'b0, q);
          tx_ones = 0;
        end
      end else tx_ones = 0;
    end
  endtask

  task automatic send_frame(input vec_t v);
    int p;
    logic [15:0] c;
    c = 16'hFFFF;
    send_flag(p);
    for (int k = 0; k < v.n; k++) begin
      send_bits(v.d[k], 8, 1'b1, k == 0);
      c = ref_crc(c, v.d[k]);
    end
    c = ~c;
    send_bits(c[7:0], 8, 1'b1, 1'b0);
    send_bits(c[15:8], 8, 1'b1, 1'b0);
    send_flag(p);
    end_sb.push_back('{at: p + 1 + LAT, fcs: v.residue});
  endtask

  initial begin
    int p;
    logic [7:0] f;
    vec_t va5;

    vecs[0] = '{n: 3, d: 32'h00030201, residue: RESIDUE};
    vecs[1] = '{n: 2, d: 32'h00007EFF, residue: RESIDUE};
    vecs[2] = '{n: 1, d: 32'h000000A5, residue: RESIDUE};
    vecs[3] = '{n: 4, d: 32'h3CFF7E00, residue: RESIDUE};
    vecs[4] = '{n: 4, d: 32'hFFFFFFFF, residue: RESIDUE};
    va5     = vecs[2];

    repeat (3) @(negedge econet_clk);
    chk("reset_fcs", {16'h0, rx_fcs}, 32'h0000FFFF);
    chk("reset_byte", {24'h0, rx_byte}, 32'h0);
    chk("reset_strobes", {28'h0, rx_byte_ready, rx_frame_start, rx_frame_end, rx_abort}, 32'h0);
    reset_n = 1'b1;
    send_ones(12);

    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i]);
      if (i % 2 == 0) send_ones(9);
    end

    // Back-to-back flags then idle: silent, decoder drops back to hunting.
    send_flag(p);
    send_flag(p);
    send_flag(p);
    send_ones(12);
    chk("idle_state", {30'h0, dut.state_q}, {30'h0, HUNT});

    // Abort after two bytes, then a normal frame.
    send_flag(p);
    send_bits(8'h12, 8, 1'b1, 1'b1);
    send_bits(8'h34, 8, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) send_raw(1'b1, p);
    abort_sb.push_back(p + 1 + LAT);
    send_ones(3);
    send_frame(va5);

    // Closing flag after 12 data bits: garbage byte E5 from the flag, no frame end.
    send_flag(p);
    send_bits(8'h11, 8, 1'b1, 1'b1);
    send_bits(8'h05, 4, 1'b0, 1'b0);
    f = 8'h7E;
    for (int i = 0; i < 8; i++) begin
      send_raw(f[i], p);
      if (i == 3) byte_sb.push_back('{at: p + 1 + LAT, start: 1'b0, data: 8'hE5});
    end
    tx_ones = 0;
    send_frame(vecs[0]);
    send_ones(9);

    // Reset mid-byte.
    send_flag(p);
    send_bits(8'h5A, 8, 1'b1, 1'b1);
    send_bits(8'h03, 4, 1'b0, 1'b0);
    @(negedge econet_clk);
    reset_n = 1'b0;
    rx      = 1'b1;
    #1;
    chk("midreset_fcs", {16'h0, rx_fcs}, 32'h0000FFFF);
    chk("midreset_byte", {24'h0, rx_byte}, 32'h0);
    chk("midreset_strobes", {28'h0, rx_byte_ready, rx_frame_start, rx_frame_end, rx_abort}, 32'h0);
    repeat (3) @(negedge econet_clk);
    reset_n = 1'b1;
    tx_ones = 0;
    send_ones(8);
    send_frame(vecs[1]);

    send_ones(8);
    repeat (10) @(negedge econet_clk);
    chk("bytes_pending", byte_sb.size(), 0);
    chk("ends_pending", end_sb.size(), 0);
    chk("aborts_pending", abort_sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
